// File: rtl/regarb_pkg.sv
// Shared types and requester indices for the register-port arbiter.
package regarb_pkg;

  typedef enum logic [0:0] {StArb, StLock} regarb_state_t;

  localparam int unsigned ReqCore = 0;
  localparam int unsigned ReqDbg  = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a tie goes to the requester that did not win last.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic [1:0] mask_i,
  input  logic       rr_last_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o
);

  logic [1:0] elig;

  assign elig = valid_i & ~mask_i;

  always_comb begin
    gnt_idx_o = 1'b0;
    gnt_o     = 2'b00;
    if (&elig) begin
      gnt_idx_o = ~rr_last_i;
    end else begin
      gnt_idx_o = elig[1];
    end
    if (|elig) begin
      gnt_o = gnt_idx_o ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/reg_port_arbiter.sv
// Shares the reg_file R1/RegWrite port between core (0) and debug (1) with round-robin and lock.
// Optional statistics counters are built when REGARB_STATS_EN is defined.
module reg_port_arbiter
  import regarb_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned D     = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [1:0]     req_valid_i,
  output logic [1:0]     req_ready_o,
  input  logic [1:0]     req_we_i,
  input  logic [2*D-1:0] req_addr_i,
  input  logic [2*W-1:0] req_wdata_i,
  output logic [1:0]     rsp_valid_o,
  output logic [W-1:0]   rsp_rdata_o,
  input  logic           dbg_lock_i,
  output logic           dbg_locked_o,
  output logic [D-1:0]   rf_r1_o,
  output logic           rf_regwrite_o,
  output logic [W-1:0]   rf_writevalue_o,
  input  logic [W-1:0]   rf_d1_i
`ifdef REGARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0_o,
  output logic [CNT_W-1:0] grant_cnt1_o,
  output logic [CNT_W-1:0] lock_cycles_o
`endif
);

  regarb_state_t state_q;
  logic          rr_last_q;
  logic [1:0]    rsp_valid_q;
  logic [W-1:0]  rsp_rdata_q;

  logic [1:0]    mask, gnt;
  logic          gnt_idx, gnt_any, sel_we, rd_fire;
  logic [D-1:0]  sel_addr;
  logic [W-1:0]  sel_wdata;

  assign mask = (state_q == StLock) ? 2'b01 << ReqCore : 2'b00;

  // No grants while reset is asserted, so nothing can be written to the register file.
  rr_arb2 u_rr_arb2 (
    .valid_i   (req_valid_i & {2{rst_ni}}),
    .mask_i    (mask),
    .rr_last_i (rr_last_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    gnt_any   = |gnt;
    sel_we    = gnt_idx ? req_we_i[1] : req_we_i[0];
    sel_addr  = gnt_idx ? req_addr_i[2*D-1:D] : req_addr_i[D-1:0];
    sel_wdata = gnt_idx ? req_wdata_i[2*W-1:W] : req_wdata_i[W-1:0];
    rd_fire   = gnt_any & ~sel_we;
  end

  assign req_ready_o     = gnt;
  assign rf_r1_o         = gnt_any ? sel_addr : '0;
  assign rf_regwrite_o   = gnt_any & sel_we;
  assign rf_writevalue_o = gnt_any ? sel_wdata : '0;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_rdata_o     = rsp_rdata_q;
  assign dbg_locked_o    = (state_q == StLock);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StArb;
      rr_last_q   <= 1'b1;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rd_fire ? gnt : 2'b00;
      if (rd_fire) begin
        rsp_rdata_q <= rf_d1_i;
      end
      unique case (state_q)
        StArb: begin
          if (gnt_any) rr_last_q <= gnt_idx;
          if (dbg_lock_i) state_q <= StLock;
        end
        StLock: begin
          // Leaving lock hands the next tie to the core.
          if (!dbg_lock_i) begin
            state_q   <= StArb;
            rr_last_q <= 1'(ReqDbg);
          end else if (gnt_any) begin
            rr_last_q <= gnt_idx;
          end
        end
        default: state_q <= StArb;
      endcase
    end
  end

`ifdef REGARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt0_q, grant_cnt1_q, lock_cycles_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_cnt0_q  <= '0;
      grant_cnt1_q  <= '0;
      lock_cycles_q <= '0;
    end else begin
      if (gnt[0] && !(&grant_cnt0_q)) grant_cnt0_q <= grant_cnt0_q + 1'b1;
      if (gnt[1] && !(&grant_cnt1_q)) grant_cnt1_q <= grant_cnt1_q + 1'b1;
      if ((state_q == StLock) && !(&lock_cycles_q)) lock_cycles_q <= lock_cycles_q + 1'b1;
    end
  end

  assign grant_cnt0_o  = grant_cnt0_q;
  assign grant_cnt1_o  = grant_cnt1_q;
  assign lock_cycles_o = lock_cycles_q;
`endif

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Bench for reg_port_arbiter: behavioural model checked every cycle plus directed literal checks.
module tb_reg_port_arbiter;

  localparam int CntW   = 4;
  localparam int CntMax = 15;

  logic        clk, rst_n;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [5:0]  req_addr;
  logic [15:0] req_wdata;
  logic [7:0]  rsp_rdata, rf_wv, rf_d1;
  logic        dbg_lock, dbg_locked, rf_regwrite;
  logic [2:0]  rf_r1;
`ifdef REGARB_STATS_EN
  logic [CntW-1:0] grant_cnt0, grant_cnt1, lock_cycles;
`endif

  int checks = 0;
  int errors = 0;

  reg_port_arbiter #(.W(8), .D(3), .CNT_W(CntW)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_we_i        (req_we),
    .req_addr_i      (req_addr),
    .req_wdata_i     (req_wdata),
    .rsp_valid_o     (rsp_valid),
    .rsp_rdata_o     (rsp_rdata),
    .dbg_lock_i      (dbg_lock),
    .dbg_locked_o    (dbg_locked),
    .rf_r1_o         (rf_r1),
    .rf_regwrite_o   (rf_regwrite),
    .rf_writevalue_o (rf_wv),
    .rf_d1_i         (rf_d1)
`ifdef REGARB_STATS_EN
    ,
    .grant_cnt0_o    (grant_cnt0),
    .grant_cnt1_o    (grant_cnt1),
    .lock_cycles_o   (lock_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file seen by the arbiter: combinational read, write at the clock edge.
  logic [7:0] rf_mem [8];
  assign rf_d1 = rf_mem[rf_r1];
  always @(posedge clk) if (rf_regwrite) rf_mem[rf_r1] <= rf_wv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drv(input logic [1:0] v, input logic [1:0] we, input logic [2:0] a0,
                     input logic [2:0] a1, input logic [7:0] d0, input logic [7:0] d1,
                     input logic lk);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    dbg_lock  = lk;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model state: what the specification says the block remembers.
  logic [7:0] m_regs [8];
  bit         m_locked;
  int         m_last;
  logic [1:0] m_rsp_valid;
  logic [7:0] m_rsp_data;
  int         m_cnt0, m_cnt1, m_lock;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_locked = 1'b0; m_last = 1; m_rsp_valid = 2'b00; m_rsp_data = 8'h00;
      m_cnt0 = 0; m_cnt1 = 0; m_lock = 0;
      chk("reset_regwrite", rf_regwrite, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_rdata", rsp_rdata, 0);
      chk("reset_locked", dbg_locked, 0);
    end else begin
      int w;
      bit can0, can1;
      logic [2:0] a;
      logic [7:0] d;
      can0 = req_valid[0] && !m_locked;
      can1 = req_valid[1];
      if (can0 && can1) w = 1 - m_last;
      else if (can0)    w = 0;
      else if (can1)    w = 1;
      else              w = -1;
      a = (w == 1) ? req_addr[5:3] : req_addr[2:0];
      d = (w == 1) ? req_wdata[15:8] : req_wdata[7:0];
      chk("model_ready", req_ready, (w < 0) ? 2'b00 : (w == 0 ? 2'b01 : 2'b10));
      chk("model_locked", dbg_locked, m_locked);
      chk("model_regwrite", rf_regwrite, (w >= 0) && req_we[w]);
      chk("model_r1", rf_r1, (w >= 0) ? a : 3'd0);
      if (w >= 0 && req_we[w]) chk("model_wvalue", rf_wv, d);
      chk("model_rsp_valid", rsp_valid, m_rsp_valid);
      if (m_rsp_valid != 2'b00) chk("model_rsp_rdata", rsp_rdata, m_rsp_data);
`ifdef REGARB_STATS_EN
      chk("model_cnt0", grant_cnt0, m_cnt0);
      chk("model_cnt1", grant_cnt1, m_cnt1);
      chk("model_lock_cycles", lock_cycles, m_lock);
`endif
      // Advance to the state after the coming clock edge.
      m_rsp_valid = 2'b00;
      if (m_locked && m_lock < CntMax) m_lock++;
      if (w >= 0) begin
        m_last = w;
        if (w == 0 && m_cnt0 < CntMax) m_cnt0++;
        if (w == 1 && m_cnt1 < CntMax) m_cnt1++;
        if (req_we[w]) begin
          m_regs[a] = d;
        end else begin
          m_rsp_valid = (w == 0) ? 2'b01 : 2'b10;
          m_rsp_data  = m_regs[a];
        end
      end
      if (!m_locked && dbg_lock) begin
        m_locked = 1'b1;
      end else if (m_locked && !dbg_lock) begin
        m_locked = 1'b0;
        m_last   = 1;
      end
    end
  end

  logic [1:0] rr_seq [4];

  initial begin
    for (int i = 0; i < 8; i++) begin
      rf_mem[i] = 8'h00;
      m_regs[i] = 8'h00;
    end
    rr_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst_n = 1'b0;
    // Valid writes during reset must not reach the register file.
    drv(2'b11, 2'b11, 3'd3, 3'd3, 8'hFF, 8'hFF, 1'b0);
    step(); step(); #3;
    chk("in_reset_regwrite", rf_regwrite, 0);
    chk("in_reset_locked", dbg_locked, 0);
    rst_n = 1'b1;
    drv(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0);
    step();

    // Core write r3 then read it back.
    drv(2'b01, 2'b01, 3'd3, 3'd0, 8'hA5, 8'h00, 1'b0); #3;
    chk("wr_ready", req_ready, 2'b01);
    chk("wr_regwrite", rf_regwrite, 1);
    chk("wr_r1", rf_r1, 3);
    step();
    drv(2'b01, 2'b00, 3'd3, 3'd0, 8'h00, 8'h00, 1'b0); #3;
    chk("rd_regwrite", rf_regwrite, 0);
    step();
    drv(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0); #3;
    chk("rd_rsp_valid", rsp_valid, 2'b01);
    chk("rd_rsp_rdata", rsp_rdata, 8'hA5);
    step();

    // Reset lands while a read response is in flight.
    drv(2'b01, 2'b00, 3'd3, 3'd0, 8'h00, 8'h00, 1'b0); #3;
    chk("midrd_ready", req_ready, 2'b01);
    step();
    rst_n = 1'b0;
    drv(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0); #3;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_rsp_rdata", rsp_rdata, 0);
    chk("midrst_locked", dbg_locked, 0);
    step();
    rst_n = 1'b1;
    step();

    // Both requesting continuously: strict alternation starting with the core.
    drv(2'b11, 2'b00, 3'd3, 3'd5, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("rr_grant", req_ready, rr_seq[i]);
      chk("rr_onehot", $countones(req_ready), 1);
      step();
    end

    // Lock: core wins this tie, then only debug until the lock drops.
    drv(2'b11, 2'b11, 3'd1, 3'd7, 8'h11, 8'h3C, 1'b1); #3;
    chk("lk0_ready", req_ready, 2'b01);
    chk("lk0_locked", dbg_locked, 0);
    step(); #3;
    chk("lk1_ready", req_ready, 2'b10);
    chk("lk1_locked", dbg_locked, 1);
    chk("lk1_r1", rf_r1, 7);
    chk("lk1_wvalue", rf_wv, 8'h3C);
    step();
    drv(2'b01, 2'b01, 3'd1, 3'd7, 8'h11, 8'h3C, 1'b1); #3;
    chk("lk2_ready", req_ready, 2'b00);
    step();
    drv(2'b11, 2'b01, 3'd1, 3'd7, 8'h11, 8'h00, 1'b0); #3;
    chk("lk3_ready", req_ready, 2'b10);
    chk("lk3_locked", dbg_locked, 1);
    step();
    drv(2'b11, 2'b00, 3'd1, 3'd7, 8'h00, 8'h00, 1'b0); #3;
    chk("unlk_ready", req_ready, 2'b01);
    chk("unlk_locked", dbg_locked, 0);
    chk("unlk_rsp_valid", rsp_valid, 2'b10);
    chk("unlk_rsp_rdata", rsp_rdata, 8'h3C);
`ifdef REGARB_STATS_EN
    chk("stat_lock_cycles", lock_cycles, 3);
`endif
    step();

    // Address boundaries r0/r7 from both requesters.
    drv(2'b01, 2'b01, 3'd0, 3'd0, 8'h5A, 8'h00, 1'b0); step();
    drv(2'b10, 2'b10, 3'd0, 3'd7, 8'h00, 8'hC3, 1'b0); step();
    drv(2'b10, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0); step();
    drv(2'b01, 2'b00, 3'd7, 3'd0, 8'h00, 8'h00, 1'b0); #3;
    chk("b_r0_dbg_valid", rsp_valid, 2'b10);
    chk("b_r0_dbg_data", rsp_rdata, 8'h5A);
    step();
    drv(2'b01, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0); #3;
    chk("b_r7_core_valid", rsp_valid, 2'b01);
    chk("b_r7_core_data", rsp_rdata, 8'hC3);
    step();
    drv(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0); #3;
    chk("b_r0_core_data", rsp_rdata, 8'h5A);
    step();

`ifdef REGARB_STATS_EN
    // Drive the core counter well past its maximum.
    drv(2'b01, 2'b01, 3'd2, 3'd0, 8'h77, 8'h00, 1'b0);
    repeat (20) step();
    drv(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0); #3;
    chk("stat_cnt0_sat", grant_cnt0, CntMax);
    step();
`endif

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
